// File: rtl/cascade_counter_pkg.sv
// Shared types and helpers for the cascaded multi-field time counter.
// Optional feature macro used by the top: AUTO_REPEAT_EN.
package cascade_counter_pkg;

  typedef enum logic [1:0] {
    RUN_UP   = 2'd0,
    RUN_DOWN = 2'd1,
    SET      = 2'd2,
    CLEAR    = 2'd3
  } mode_t;

  // Widest packed vector / field the helper can slice.
  localparam int unsigned VEC_W = 64;
  localparam int unsigned FLD_W = 16;

  // Extract field idx of width fw from a packed field vector.
  function automatic logic [FLD_W-1:0] field_of(input logic [VEC_W-1:0] vec,
                                                input int unsigned       idx,
                                                input int unsigned       fw);
    logic [VEC_W-1:0] sh;
    sh = (vec >> (idx * fw)) & ((VEC_W'(1) << fw) - VEC_W'(1));
    return FLD_W'(sh);
  endfunction

endpackage

// File: rtl/hold_repeater.sv
// Turns a held step-request level into step pulses: one on the rising edge,
// one more after HOLD_CYC cycles held, then one every RPT_CYC cycles.
// Dropping the level or i_en restarts the sequence.
module hold_repeater #(
  parameter int unsigned HOLD_CYC = 50_000_000,
  parameter int unsigned RPT_CYC  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_lvl,
  output logic o_step
);

  localparam int unsigned TMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] RPT_LD  = TW'(RPT_CYC - 1);

  logic          r_prev;
  logic [TW-1:0] r_tmr;
  logic          w_act;
  logic          w_rise;

  assign w_act  = i_en & i_lvl;
  assign w_rise = w_act & ~r_prev;
  // Timer reaching zero while still held is the repeat point.
  assign o_step = w_rise | (w_act & r_prev & (r_tmr == '0));

  // Edge tracking and hold/repeat down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_tmr  <= '0;
    end else begin
      r_prev <= w_act;
      if (!w_act)
        r_tmr <= '0;
      else if (w_rise)
        r_tmr <= HOLD_LD;
      else if (r_tmr == '0)
        r_tmr <= RPT_LD;
      else
        r_tmr <= r_tmr - 1'b1;
    end
  end

endmodule

// File: rtl/cascade_time_counter.sv
// Multi-field cascaded counter (e.g. HH:MM:SS) with per-field radix,
// up/down run, per-field set and clamped parallel load.
// Define AUTO_REPEAT_EN to make inc/dec held levels with hold/repeat stepping;
// otherwise every asserted inc/dec cycle in SET is one step.
module cascade_time_counter
  import cascade_counter_pkg::*;
#(
  parameter int unsigned       NF       = 3,
  parameter int unsigned       FW       = 6,
  parameter logic [NF*FW-1:0]  MAX_VEC  = {6'd23, 6'd59, 6'd59},
  parameter int unsigned       HOLD_CYC = 50_000_000,
  parameter int unsigned       RPT_CYC  = 10_000_000,
  localparam int unsigned      SELW     = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  mode_t            i_mode,
  input  logic [SELW-1:0]  i_sel,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic [NF*FW-1:0] i_load_val,
  output logic [NF*FW-1:0] o_cnt,
  output logic             o_carry_out,
  output logic             o_done
);

  logic [NF*FW-1:0] r_cnt;
  logic             r_carry;
  logic             r_done;

  logic [NF:0]      w_all_max;
  logic [NF:0]      w_all_zero;
  logic [NF*FW-1:0] w_up_cnt;
  logic [NF*FW-1:0] w_dn_cnt;
  logic [NF*FW-1:0] w_set_cnt;
  logic [NF*FW-1:0] w_load_cnt;
  logic             w_inc_step;
  logic             w_dec_step;

`ifdef AUTO_REPEAT_EN
  hold_repeater #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_rep_inc (
    .clk    (clk),
    .reset  (reset),
    .i_en   (i_mode == SET),
    .i_lvl  (i_inc),
    .o_step (w_inc_step)
  );

  hold_repeater #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_rep_dec (
    .clk    (clk),
    .reset  (reset),
    .i_en   (i_mode == SET),
    .i_lvl  (i_dec),
    .o_step (w_dec_step)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(HOLD_CYC), 32'(RPT_CYC)};
  assign w_inc_step   = i_inc;
  assign w_dec_step   = i_dec;
`endif

  // Field i moves only when every lower field sits at its wrap point.
  assign w_all_max[0]  = 1'b1;
  assign w_all_zero[0] = 1'b1;

  for (genvar gi = 0; gi < NF; gi++) begin : g_field
    logic [FW-1:0] w_f;
    logic [FW-1:0] w_m;
    logic [FW-1:0] w_lv;
    logic [FW-1:0] w_inc_v;
    logic [FW-1:0] w_dec_v;
    logic          w_at_max;
    logic          w_at_zero;
    logic          w_sel_hit;

    assign w_f       = FW'(field_of(VEC_W'(r_cnt), gi, FW));
    assign w_m       = FW'(field_of(VEC_W'(MAX_VEC), gi, FW));
    assign w_lv      = FW'(field_of(VEC_W'(i_load_val), gi, FW));
    assign w_at_max  = (w_f == w_m);
    assign w_at_zero = (w_f == '0);
    assign w_inc_v   = w_at_max  ? '0  : w_f + 1'b1;
    assign w_dec_v   = w_at_zero ? w_m : w_f - 1'b1;
    assign w_sel_hit = (i_sel == SELW'(gi));

    assign w_all_max[gi+1]  = w_all_max[gi]  & w_at_max;
    assign w_all_zero[gi+1] = w_all_zero[gi] & w_at_zero;

    assign w_up_cnt[gi*FW +: FW]   = w_all_max[gi]  ? w_inc_v : w_f;
    assign w_dn_cnt[gi*FW +: FW]   = w_all_zero[gi] ? w_dec_v : w_f;
    assign w_set_cnt[gi*FW +: FW]  = w_sel_hit ? (w_inc_step ? w_inc_v : w_dec_v) : w_f;
    assign w_load_cnt[gi*FW +: FW] = (w_lv > w_m) ? w_m : w_lv;
  end

  // Counter update with load > CLEAR > SET step > RUN tick priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      if (i_load) begin
        r_cnt <= w_load_cnt;
      end else begin
        case (i_mode)
          CLEAR: r_cnt <= '0;
          SET: begin
            if (w_inc_step ^ w_dec_step)
              r_cnt <= w_set_cnt;
          end
          RUN_UP: begin
            if (i_tick) begin
              r_cnt   <= w_up_cnt;
              r_carry <= w_all_max[NF];
            end
          end
          RUN_DOWN: begin
            // An all-zero count parks; done marks only the step into zero.
            if (i_tick && !w_all_zero[NF]) begin
              r_cnt  <= w_dn_cnt;
              r_done <= (w_dn_cnt == '0);
            end
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign o_cnt       = r_cnt;
  assign o_carry_out = r_carry;
  assign o_done      = r_done;

endmodule

// File: tb/tb_cascade_time_counter.sv
// Directed self-checking bench for cascade_time_counter (HH:MM:SS defaults).
module tb_cascade_time_counter;
  import cascade_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_tick;
  mode_t       i_mode;
  logic [1:0]  i_sel;
  logic        i_inc;
  logic        i_dec;
  logic        i_load;
  logic [17:0] i_load_val;
  logic [17:0] o_cnt;
  logic        o_carry_out;
  logic        o_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cascade_time_counter #(.HOLD_CYC(4), .RPT_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_tick      (i_tick),
    .i_mode      (i_mode),
    .i_sel       (i_sel),
    .i_inc       (i_inc),
    .i_dec       (i_dec),
    .i_load      (i_load),
    .i_load_val  (i_load_val),
    .o_cnt       (o_cnt),
    .o_carry_out (o_carry_out),
    .o_done      (o_done)
  );

  function automatic logic [17:0] pk(input int f2, input int f1, input int f0);
    return {6'(f2), 6'(f1), 6'(f0)};
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_tick = 1'b0; i_mode = RUN_UP; i_sel = 2'd0;
    i_inc = 1'b0; i_dec = 1'b0; i_load = 1'b0; i_load_val = '0;
    #12;
    chk("rst_cnt", o_cnt, pk(0, 0, 0));
    chk("rst_carry", 18'(o_carry_out), 18'd0);
    chk("rst_done", 18'(o_done), 18'd0);
    reset = 1'b0;

    // RUN_UP wrap of all fields
    i_load = 1'b1; i_load_val = pk(23, 59, 58); cyc();
    chk("up_load", o_cnt, pk(23, 59, 58));
    i_load = 1'b0; i_tick = 1'b1; cyc();
    chk("up_t1", o_cnt, pk(23, 59, 59));
    chk("up_t1_carry", 18'(o_carry_out), 18'd0);
    cyc();
    chk("up_wrap", o_cnt, pk(0, 0, 0));
    chk("up_wrap_carry", 18'(o_carry_out), 18'd1);
    i_tick = 1'b0; cyc();
    chk("up_idle", o_cnt, pk(0, 0, 0));
    chk("up_carry_clr", 18'(o_carry_out), 18'd0);
    i_tick = 1'b1; cyc();
    chk("up_plain", o_cnt, pk(0, 0, 1));
    i_tick = 1'b0;
    i_load = 1'b1; i_load_val = pk(3, 59, 59); cyc();
    i_load = 1'b0; i_tick = 1'b1; cyc();
    chk("up_ripple", o_cnt, pk(4, 0, 0));
    chk("up_ripple_carry", 18'(o_carry_out), 18'd0);
    i_tick = 1'b0;

    // RUN_DOWN borrow and done
    i_mode = RUN_DOWN;
    i_load = 1'b1; i_load_val = pk(0, 1, 0); cyc();
    i_load = 1'b0; i_tick = 1'b1; cyc();
    chk("dn_borrow", o_cnt, pk(0, 0, 59));
    chk("dn_borrow_done", 18'(o_done), 18'd0);
    i_tick = 1'b0;
    i_load = 1'b1; i_load_val = pk(1, 0, 0); cyc();
    i_load = 1'b0; i_tick = 1'b1; cyc();
    chk("dn_borrow2", o_cnt, pk(0, 59, 59));
    i_tick = 1'b0;
    i_load = 1'b1; i_load_val = pk(0, 0, 1); cyc();
    i_load = 1'b0; i_tick = 1'b1; cyc();
    chk("dn_zero", o_cnt, pk(0, 0, 0));
    chk("dn_done", 18'(o_done), 18'd1);
    cyc();
    chk("dn_hold", o_cnt, pk(0, 0, 0));
    chk("dn_hold_done", 18'(o_done), 18'd0);
    cyc();
    chk("dn_hold2", o_cnt, pk(0, 0, 0));
    chk("dn_hold2_done", 18'(o_done), 18'd0);
    i_tick = 1'b0;

    // SET stepping of a single field
    i_mode = SET; i_sel = 2'd1;
    i_load = 1'b1; i_load_val = pk(5, 59, 10); cyc();
    i_load = 1'b0; i_inc = 1'b1; cyc();
    chk("set_inc_wrap", o_cnt, pk(5, 0, 10));
    i_inc = 1'b0; cyc();
    chk("set_idle", o_cnt, pk(5, 0, 10));
    i_dec = 1'b1; cyc();
    chk("set_dec_wrap", o_cnt, pk(5, 59, 10));
    i_dec = 1'b0; cyc();
    i_inc = 1'b1; i_dec = 1'b1; cyc();
    chk("set_both", o_cnt, pk(5, 59, 10));
    i_inc = 1'b0; i_dec = 1'b0; cyc();
    i_tick = 1'b1; cyc();
    chk("set_tick_ign", o_cnt, pk(5, 59, 10));
    i_tick = 1'b0;
    i_sel = 2'd3; i_inc = 1'b1; cyc();
    chk("set_sel_oob", o_cnt, pk(5, 59, 10));
    i_inc = 1'b0; cyc();
    i_sel = 2'd0; i_dec = 1'b1; cyc();
    chk("set_f0_dec", o_cnt, pk(5, 59, 9));
    i_dec = 1'b0; cyc();
    i_sel = 2'd2; i_inc = 1'b1; cyc();
    chk("set_f2_inc", o_cnt, pk(6, 59, 9));
    i_inc = 1'b0; cyc();

    // Clamped load, load over CLEAR, CLEAR, mode change retention
    i_mode = RUN_UP;
    i_load = 1'b1; i_load_val = pk(30, 63, 5); cyc();
    chk("load_clamp", o_cnt, pk(23, 59, 5));
    i_mode = CLEAR; i_load_val = pk(1, 2, 3); cyc();
    chk("load_over_clear", o_cnt, pk(1, 2, 3));
    i_load = 1'b0; i_tick = 1'b1; cyc();
    chk("clear", o_cnt, pk(0, 0, 0));
    i_tick = 1'b0;
    i_load = 1'b1; i_load_val = pk(4, 5, 6); cyc();
    i_load = 1'b0; i_mode = RUN_DOWN; cyc();
    chk("mode_keep", o_cnt, pk(4, 5, 6));

    // Async reset between edges
    i_mode = RUN_UP; i_tick = 1'b1; cyc(); cyc();
    chk("pre_reset", o_cnt, pk(4, 5, 8));
    #2 reset = 1'b1;
    #1;
    chk("async_reset", o_cnt, pk(0, 0, 0));
    #2 reset = 1'b0;
    cyc();
    chk("resume1", o_cnt, pk(0, 0, 1));
    cyc();
    chk("resume2", o_cnt, pk(0, 0, 2));
    i_tick = 1'b0;

    // Held inc behaviour
    i_mode = SET; i_sel = 2'd0;
    i_load = 1'b1; i_load_val = pk(0, 0, 0); cyc();
    i_load = 1'b0;
`ifdef AUTO_REPEAT_EN
    begin
      int exp_rep [9] = '{1, 1, 1, 1, 2, 2, 3, 3, 4};
      i_inc = 1'b1;
      for (int k = 0; k < 9; k++) begin
        cyc();
        chk($sformatf("rep_c%0d", k), o_cnt, pk(0, 0, exp_rep[k]));
      end
      i_inc = 1'b0; cyc();
      chk("rep_release", o_cnt, pk(0, 0, 4));
      i_inc = 1'b1; cyc();
      chk("rep_restart", o_cnt, pk(0, 0, 5));
      i_inc = 1'b0; cyc();
    end
`else
    i_inc = 1'b1; cyc();
    chk("pulse_c0", o_cnt, pk(0, 0, 1));
    cyc();
    chk("pulse_c1", o_cnt, pk(0, 0, 2));
    i_inc = 1'b0; cyc();
    chk("pulse_idle", o_cnt, pk(0, 0, 2));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
